// File: rtl/pipelined_subtractor.sv
// Pipelined WIDTH-bit subtractor: d = a - b - bin, with borrow-out bo.
// One SEG-bit segment is resolved per stage and the borrow is registered between stages.
module pipelined_subtractor #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bo
);
    localparam int STAGES = WIDTH / SEG;

    if ((SEG < 1) || (SEG > WIDTH) || ((WIDTH % SEG) != 0)) begin : g_bad_params
        $error("pipelined_subtractor: WIDTH must be a non-zero multiple of SEG");
    end

    // Per-stage registers; a/b travel whole so later stages find their segments in place.
    logic             valid_reg  [STAGES];
    logic             borrow_reg [STAGES];
    logic [WIDTH-1:0] a_reg      [STAGES];
    logic [WIDTH-1:0] b_reg      [STAGES];
    logic [WIDTH-1:0] d_reg      [STAGES];

    logic             valid_src  [STAGES];
    logic             borrow_src [STAGES];
    logic [WIDTH-1:0] a_src      [STAGES];
    logic [WIDTH-1:0] b_src      [STAGES];
    logic [WIDTH-1:0] d_src      [STAGES];
    logic             borrow_next[STAGES];
    logic [WIDTH-1:0] d_next     [STAGES];

    logic stall;

    assign out_valid = valid_reg[STAGES-1];
    assign d         = d_reg[STAGES-1];
    assign bo        = borrow_reg[STAGES-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam logic [WIDTH-1:0] SEG_MASK = {{(WIDTH-SEG){1'b0}}, {SEG{1'b1}}} << (gi * SEG);
        logic [SEG:0] seg_diff;

        if (gi == 0) begin : g_head
            assign valid_src[gi]  = in_valid;
            assign a_src[gi]      = a;
            assign b_src[gi]      = b;
            assign borrow_src[gi] = bin;
            assign d_src[gi]      = '0;
        end else begin : g_tail
            assign valid_src[gi]  = valid_reg[gi-1];
            assign a_src[gi]      = a_reg[gi-1];
            assign b_src[gi]      = b_reg[gi-1];
            assign borrow_src[gi] = borrow_reg[gi-1];
            assign d_src[gi]      = d_reg[gi-1];
        end

        // SEG+1-bit subtraction: the extra MSB is the borrow into the next stage.
        assign seg_diff = {1'b0, a_src[gi][gi*SEG +: SEG]}
                        - {1'b0, b_src[gi][gi*SEG +: SEG]}
                        - {{SEG{1'b0}}, borrow_src[gi]};

        assign borrow_next[gi] = seg_diff[SEG];
        assign d_next[gi]      = (d_src[gi] & ~SEG_MASK)
                               | (WIDTH'(seg_diff[SEG-1:0]) << (gi * SEG));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_reg[k]  <= 1'b0;
                borrow_reg[k] <= 1'b0;
                a_reg[k]      <= '0;
                b_reg[k]      <= '0;
                d_reg[k]      <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_reg[k] <= valid_src[k];
                // Bubbles leave the data registers untouched to save toggling.
                if (valid_src[k]) begin
                    borrow_reg[k] <= borrow_next[k];
                    a_reg[k]      <= a_src[k];
                    b_reg[k]      <= b_src[k];
                    d_reg[k]      <= d_next[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_subtractor.sv
// Self-checking bench for pipelined_subtractor (WIDTH=16, SEG=4): an arithmetic
// reference model feeds an in-order queue that a per-cycle monitor checks against.
module tb_pipelined_subtractor;
    localparam int WIDTH  = 16;
    localparam int SEG    = 4;
    localparam int STAGES = WIDTH / SEG;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bo;

    pipelined_subtractor #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .bo(bo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bo;
        int               acc_cycle;
        int               acc_stalls;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;
    int   stall_count = 0;
    int   delivered = 0;
    int   accepted  = 0;
    logic rst_seen  = 1'b0;
    logic prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_d = '0;
    logic prev_bo = 1'b0;
    logic front_checked = 1'b0;
    logic bp_mode = 1'b0;

    // Reference: plain unsigned arithmetic one bit wider than the operands.
    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic bi);
        logic [WIDTH:0] r;
        r = {1'b0, x} - {1'b0, y} - (WIDTH+1)'(bi);
        return r;
    endfunction

    task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(posedge clk) begin
        cycle++;
        rst_seen = rst;
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (cycle >= 1) begin
            if (rst_seen)
                check("reset_state", !out_valid && d == '0 && !bo, {15'd0, out_valid, bo, d}, 32'h0);
            check("in_ready", in_ready == !(out_valid && !out_ready), {31'd0, in_ready},
                  {31'd0, !(out_valid && !out_ready)});
            if (prev_stall && !rst_seen)
                check("stall_hold", out_valid && d == prev_d && bo == prev_bo,
                      {15'd0, out_valid, bo, d}, {15'd1, 1'b1, prev_bo, prev_d});
            if (out_valid) begin
                check("out_has_expected", q.size() != 0, {15'd0, bo, d}, 32'h0);
                if (q.size() != 0) begin
                    check("result", d == q[0].d && bo == q[0].bo, {15'd0, bo, d}, {15'd0, q[0].bo, q[0].d});
                    if (!front_checked && q[0].acc_stalls == stall_count)
                        check("latency", (cycle - q[0].acc_cycle) == STAGES,
                              32'(cycle - q[0].acc_cycle), 32'(STAGES));
                    front_checked = 1'b1;
                end
            end
            if (rst) begin
                q.delete();
                front_checked = 1'b0;
            end else begin
                if (out_valid && out_ready && q.size() != 0) begin
                    void'(q.pop_front());
                    front_checked = 1'b0;
                    delivered++;
                end
                if (in_valid && in_ready) begin
                    exp_t e;
                    logic [WIDTH:0] r;
                    r = ref_sub(a, b, bin);
                    e.d = r[WIDTH-1:0];
                    e.bo = r[WIDTH];
                    e.acc_cycle = cycle;
                    e.acc_stalls = stall_count;
                    q.push_back(e);
                    accepted++;
                end
            end
            if (out_valid && !out_ready && !rst) stall_count++;
            prev_stall = out_valid && !out_ready && !rst;
            prev_d = d;
            prev_bo = bo;
        end
    end

    // Random backpressure, including forced runs of five low cycles.
    initial begin
        int run = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                if (run > 0) begin
                    run--;
                    out_ready = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    run = 4;
                    out_ready = 1'b0;
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic bi);
        logic acc;
        int   n;
        in_valid = 1'b1;
        a = x;
        b = y;
        bin = bi;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready && !rst;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) check("send_timeout", 1'b0, 32'(n), 32'd100);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", q.size() == 0, 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Hand-computed vectors pinning the model itself.
    logic [WIDTH-1:0] vec_a  [6] = '{16'h1234, 16'h0000, 16'h8000, 16'h0005, 16'h0005, 16'hFFFF};
    logic [WIDTH-1:0] vec_b  [6] = '{16'h0235, 16'h0000, 16'h0001, 16'h0005, 16'h0005, 16'h0000};
    logic             vec_bi [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [WIDTH-1:0] vec_d  [6] = '{16'h0FFF, 16'hFFFF, 16'h7FFF, 16'h0000, 16'hFFFF, 16'hFFFE};
    logic             vec_bo [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [WIDTH:0] r;
        rst = 1'b1;
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h0235;
        bin = 1'b0;
        out_ready = 1'b1;

        for (int i = 0; i < 6; i++) begin
            r = ref_sub(vec_a[i], vec_b[i], vec_bi[i]);
            check("model_pin", r[WIDTH-1:0] == vec_d[i] && r[WIDTH] == vec_bo[i],
                  {15'd0, r}, {15'd0, vec_bo[i], vec_d[i]});
        end

        // Reset held three edges with operands already offered.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("first_accept", accepted == 1, 32'(accepted), 32'd1);
        drain();

        // Full borrow ripple.
        send(16'h0000, 16'h0000, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        send(16'h8000, 16'h0001, 1'b0);
        drain();

        // Back-to-back random stream.
        for (int i = 0; i < 100; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        drain();

        // Random backpressure.
        bp_mode = 1'b1;
        for (int i = 0; i < 60; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        bp_mode = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with three transactions in flight.
        send(16'hAAAA, 16'h1111, 1'b0);
        send(16'hBBBB, 16'h2222, 1'b1);
        send(16'hCCCC, 16'h3333, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(16'h4321, 16'h1234, 1'b1);
        send(16'h0001, 16'h0002, 1'b0);
        drain();
        repeat (6) @(posedge clk);
        #1;

        check("all_delivered", delivered == accepted - 3, 32'(delivered), 32'(accepted - 3));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
